pilha_chamadas: RTL
===================

# pilha_chamadas

Parametrised hardware return-address stack: the successor to the fixed 16-entry, 32-bit call stack in the processor datapath. It stores return addresses on call (push), delivers them on return (pop), supports simultaneous push+pop (tail-call replace), and reports occupancy plus sticky overflow/underflow errors. It sits between the PC update logic and the control unit, and its state advances on the processor clock.

## Interface
- DATA_W, 32, width of each stored entry (return address)
- DEPTH, 16, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

- clk  in  1  processor clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- push  in  1  write push_data as the new top this cycle
- pop  in  1  remove the current top this cycle
- push_data  in  DATA_W  value to push
- clr_err  in  1  clear the sticky error flags
- top_data  out  DATA_W  current top entry; 0 when empty
- count  out  CNT_W  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: push refused or overwrote the oldest entry
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×DATA_W array with write pointer wp, range 0..DEPTH-1, circular arithmetic mod DEPTH. Top = mem[wp-1].
- Per cycle, with count before the edge:
  - push only, not full: mem[wp]←push_data; wp+1; count+1.
  - push only, full: behaviour set by the configuration macro (see Configuration). overflow←1.
  - pop only, not empty: wp-1; count-1. Memory contents are unchanged.
  - pop only, empty: no state change. underflow←1.
  - push+pop, not empty: mem[wp-1]←push_data; wp and count unchanged. No error, even when full.
  - push+pop, empty: treated as push only. count←1. No underflow.
  - neither: hold.
- clr_err clears overflow and underflow. If a new error occurs in the same cycle, the new error wins and the flag ends at 1.
- top_data, empty and full are decoded from registered state only. There is no combinational path from push, pop or push_data to any output. top_data is forced to 0 when empty.
- reset: wp=0, count=0, overflow=0, underflow=0, so top_data=0, empty=1, full=0. Array contents are not cleared. Reset asserted mid-operation discards the stack immediately and asynchronously.

## Timing
- Zero-cycle operation latency: the effect of push or pop sampled at edge N is visible on top_data and count right after edge N.
- A pop at edge N and a push at edge N+1 are independent. Back-to-back operations are sustained every cycle with no bubbles.
- Error flags assert right after the offending edge and stay asserted until clr_err or reset.
- Reset deassertion is synchronised by the instantiating design. The block needs no extra cycles after reset.

## Configuration
- PILHA_WRAP_EN defined: push on full overwrites the oldest entry (mem[wp]←push_data; wp+1). count stays DEPTH, top_data = push_data, and overflow←1. This gives a circular call stack for unbounded recursion that only needs recent returns.
- PILHA_WRAP_EN undefined: push on full is ignored. wp, count and the array are unchanged, and overflow←1.

## Structure
- Shared package pilha_pkg holds:
  - default DATA_W/DEPTH localparams
  - the op encoding (OP_NONE, OP_PUSH, OP_POP, OP_REPLACE) built from {push,pop}
  - a pointer-width function.
- Sub-module pilha_mem: a 1-write/1-read register array. It has synchronous write and asynchronous read at an address driven from registered wp. It has no reset.
- pilha_chamadas holds the pointer/count/flag logic and the op decode.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles → top_data 0x300, count 3. Pop three times → top_data 0x200, 0x100, then 0 with empty=1.
- Push 0xA then push+pop with 0xB → count 1, top_data 0xB, no flags. Push+pop while empty with 0xC → count 1, top_data 0xC, underflow=0.
- Pop while empty → underflow=1, count 0. Assert clr_err together with a second empty pop → underflow stays 1. Assert clr_err alone → underflow 0.
- DEPTH=4: push 1..5.
  - Without PILHA_WRAP_EN: count 4, top_data 4, overflow=1. Popping 4 times yields 4,3,2,1.
  - With the macro: top_data 5, count 4. Popping yields 5,4,3,2.
- Push 0x11, 0x22, assert reset for part of a cycle, release → count 0, empty=1, top_data 0, flags 0. Push 0x33 → top_data 0x33.
- DATA_W=16, DEPTH=8: randomised push/pop/replace for 10k cycles against a queue model → top_data, count and flags match every cycle.

Source files
------------

// File: rtl/pilha_pkg.sv
// pilha_pkg: shared definitions for the return-address stack.
//   DEF_DATA_W / DEF_DEPTH : default entry width and entry count
//   op_t                   : operation decoded from {push, pop}
//   ptr_w()                : pointer width for a given depth
package pilha_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pilha_mem.sv
// pilha_mem: 1-write/1-read register array for the call stack.
// Synchronous write, asynchronous read, no reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (driven from registered state)
//   rdata : read data
module pilha_mem
  import pilha_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = ptr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pilha_chamadas.sv
// pilha_chamadas: parametrised return-address stack.
// Push stores a return address, pop removes it, push+pop replaces the top
// (tail call). Occupancy and sticky overflow/underflow are reported.
// Build option: PILHA_WRAP_EN - when defined, push on full overwrites the
// oldest entry (circular stack); otherwise push on full is dropped.
//   clk       : processor clock
//   reset     : asynchronous active-high reset of control state
//   push/pop  : operation requests, push_data is the value to push
//   clr_err   : clear sticky flags (a same-cycle new error wins)
//   top_data  : current top entry, 0 when empty
//   count     : valid entries 0..DEPTH; empty/full decoded from it
//   overflow  : sticky, push on full
//   underflow : sticky, pop on empty
module pilha_chamadas
  import pilha_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  op_t              op;
  logic [PTR_W-1:0] wp, wp_nxt, top_addr, waddr;
  logic [CNT_W-1:0] cnt_nxt;
  logic             we, ovf_set, udf_set;
  logic [DATA_W-1:0] rd_data;

  assign op       = op_t'({push, pop});
  assign top_addr = wp - PTR_W'(1);
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign top_data = empty ? '0 : rd_data;

  always_comb begin
    we      = 1'b0;
    waddr   = wp;
    wp_nxt  = wp;
    cnt_nxt = count;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          wp_nxt  = wp + PTR_W'(1);
          cnt_nxt = count + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
`ifdef PILHA_WRAP_EN
          // Slot at wp holds the oldest entry when full; overwrite it.
          we      = 1'b1;
          wp_nxt  = wp + PTR_W'(1);
`endif
        end
      end
      OP_POP: begin
        if (!empty) begin
          wp_nxt  = wp - PTR_W'(1);
          cnt_nxt = count - CNT_W'(1);
        end else begin
          udf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        // Replace on empty degenerates to a plain push (never full here).
        if (empty) begin
          we      = 1'b1;
          wp_nxt  = wp + PTR_W'(1);
          cnt_nxt = count + CNT_W'(1);
        end else begin
          we      = 1'b1;
          waddr   = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wp_nxt;
      count     <= cnt_nxt;
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

  pilha_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (top_addr),
    .rdata (rd_data)
  );

endmodule
